reset_sequencer: RTL and testbench

- Consumes the synchronized system reset and releases SoC reset domains in a fixed order: peripherals/interconnect first, then the rv32im core.
- Also services a software/debug reset request from the core, replaying the full sequence.
- Sits directly downstream of the reset synchronizer; its outputs drive every domain reset in the SoC.

---
 rtl/soc_rst_pkg.sv | 28 ++
 rtl/reset_sequencer.sv | 172 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/soc_rst_pkg.sv
// -----------------------------------------------------------------------------
// soc_rst_pkg
// Shared definitions for the SoC reset sequencing logic.
//   rst_state_e     : 2-bit sequencer state encoding
//   RST_CAUSE_*     : reset cause codes reported to software
//   hold_param_ok() : range check used for elaboration-time parameter checks
// -----------------------------------------------------------------------------
package soc_rst_pkg;

    typedef enum logic [1:0] {
        ST_PERIPH_HOLD = 2'b00,
        ST_CORE_HOLD   = 2'b01,
        ST_RUN         = 2'b10,
        ST_SW_RST      = 2'b11
    } rst_state_e;

    localparam logic [1:0] RST_CAUSE_POR = 2'b00;
    localparam logic [1:0] RST_CAUSE_SW  = 2'b01;
    // 2'b10 and 2'b11 are reserved for watchdog and debug resets.
    localparam logic [1:0] RST_CAUSE_WDT = 2'b10;
    localparam logic [1:0] RST_CAUSE_DBG = 2'b11;

    // A hold length is legal when it fits in the counter and is non-zero.
    function automatic bit hold_param_ok(input int value, input int cnt_w);
        return (value >= 1) && (value <= ((1 << cnt_w) - 1));
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Releases SoC reset domains in order after the synchronized system reset:
// peripherals/interconnect first, then the CPU core. A software/debug reset
// request accepted while running replays the whole sequence.
//
// Ports
//   clk           in   system clock
//   reset         in   async active-high reset (deasserts synchronously)
//   sw_rst_req_i  in   software/debug reset request (level, sampled each clk)
//   ext_hold_i    in   keeps the core in reset while high (CORE_HOLD only)
//   periph_rst_o  out  active-high peripheral/interconnect reset
//   core_rst_o    out  active-high CPU core reset
//   sys_ready_o   out  high while both resets are released
//   sw_rst_ack_o  out  one-cycle acknowledge of an accepted software reset
//   rst_cause_o   out  cause of the last reset (00 power-on, 01 software)
// -----------------------------------------------------------------------------
module reset_sequencer
    import soc_rst_pkg::*;
#(
    parameter int PERIPH_HOLD = 16,
    parameter int CORE_HOLD   = 8,
    parameter int SWRST_PULSE = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_rst_req_i,
    input  logic       ext_hold_i,
    output logic       periph_rst_o,
    output logic       core_rst_o,
    output logic       sys_ready_o,
    output logic       sw_rst_ack_o,
    output logic [1:0] rst_cause_o
);

    generate
        if (!hold_param_ok(PERIPH_HOLD, CNT_W) ||
            !hold_param_ok(CORE_HOLD, CNT_W)   ||
            !hold_param_ok(SWRST_PULSE, CNT_W)) begin : g_bad_params
            $error("reset_sequencer: hold parameters must lie in 1..2**CNT_W-1");
        end
    endgenerate

    // Terminal count values for each phase of the shared hold counter.
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_HOLD - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] SWRST_LAST  = CNT_W'(SWRST_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    rst_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_periph_rst;
    logic             r_core_rst;
    logic             r_sys_ready;
    logic             r_sw_rst_ack;
    logic [1:0]       r_rst_cause;

    rst_state_e       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_periph_rst_next;
    logic             w_core_rst_next;
    logic             w_sys_ready_next;
    logic             w_sw_rst_ack_next;
    logic [1:0]       w_rst_cause_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_PERIPH_HOLD;
            r_cnt        <= '0;
            r_periph_rst <= 1'b1;
            r_core_rst   <= 1'b1;
            r_sys_ready  <= 1'b0;
            r_sw_rst_ack <= 1'b0;
            r_rst_cause  <= RST_CAUSE_POR;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_periph_rst <= w_periph_rst_next;
            r_core_rst   <= w_core_rst_next;
            r_sys_ready  <= w_sys_ready_next;
            r_sw_rst_ack <= w_sw_rst_ack_next;
            r_rst_cause  <= w_rst_cause_next;
        end
    end

    // Every state drives both resets explicitly, so periph_rst high always
    // implies core_rst high and sys_ready always tracks !core_rst.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_periph_rst_next = r_periph_rst;
        w_core_rst_next   = r_core_rst;
        w_sys_ready_next  = r_sys_ready;
        w_sw_rst_ack_next = 1'b0;
        w_rst_cause_next  = r_rst_cause;

        case (r_state)
            ST_PERIPH_HOLD: begin
                w_periph_rst_next = 1'b1;
                w_core_rst_next   = 1'b1;
                w_sys_ready_next  = 1'b0;
                if (r_cnt == PERIPH_LAST) begin
                    w_periph_rst_next = 1'b0;
                    w_cnt_next        = '0;
                    w_state_next      = ST_CORE_HOLD;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            ST_CORE_HOLD: begin
                w_periph_rst_next = 1'b0;
                w_core_rst_next   = 1'b1;
                w_sys_ready_next  = 1'b0;
                // Counter saturates so an arbitrarily long external hold
                // releases on the first edge it is sampled low.
                if (r_cnt == CORE_LAST) begin
                    if (!ext_hold_i) begin
                        w_core_rst_next  = 1'b0;
                        w_sys_ready_next = 1'b1;
                        w_state_next     = ST_RUN;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            ST_RUN: begin
                w_periph_rst_next = 1'b0;
                w_core_rst_next   = 1'b0;
                w_sys_ready_next  = 1'b1;
                if (sw_rst_req_i) begin
                    w_periph_rst_next = 1'b1;
                    w_core_rst_next   = 1'b1;
                    w_sys_ready_next  = 1'b0;
                    w_sw_rst_ack_next = 1'b1;
                    w_rst_cause_next  = RST_CAUSE_SW;
                    w_cnt_next        = '0;
                    w_state_next      = ST_SW_RST;
                end
            end

            ST_SW_RST: begin
                w_periph_rst_next = 1'b1;
                w_core_rst_next   = 1'b1;
                w_sys_ready_next  = 1'b0;
                if (r_cnt == SWRST_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_PERIPH_HOLD;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_next      = ST_PERIPH_HOLD;
                w_cnt_next        = '0;
                w_periph_rst_next = 1'b1;
                w_core_rst_next   = 1'b1;
                w_sys_ready_next  = 1'b0;
            end
        endcase
    end

    assign periph_rst_o = r_periph_rst;
    assign core_rst_o   = r_core_rst;
    assign sys_ready_o  = r_sys_ready;
    assign sw_rst_ack_o = r_sw_rst_ack;
    assign rst_cause_o  = r_rst_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer: each scenario pushes the output vector
// {periph, core, ready, ack, cause[1:0]} expected at given edge numbers, and a
// monitor pops and compares them 1 time unit after the matching clk edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       sw_rst_req_i;
    logic       ext_hold_i;
    logic       periph_rst_o;
    logic       core_rst_o;
    logic       sys_ready_o;
    logic       sw_rst_ack_o;
    logic [1:0] rst_cause_o;

    reset_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sw_rst_req_i (sw_rst_req_i),
        .ext_hold_i   (ext_hold_i),
        .periph_rst_o (periph_rst_o),
        .core_rst_o   (core_rst_o),
        .sys_ready_o  (sys_ready_o),
        .sw_rst_ack_o (sw_rst_ack_o),
        .rst_cause_o  (rst_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge 1 is the first rising edge with reset low.
    int edge_cnt = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        string      tag;
        int         edge_n;
        logic [5:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [5:0] v(input logic p, input logic c, input logic r,
                                     input logic a, input logic [1:0] cs);
        return {p, c, r, a, cs};
    endfunction

    function automatic logic [5:0] outs();
        return {periph_rst_o, core_rst_o, sys_ready_o, sw_rst_ack_o, rst_cause_o};
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int e, input logic [5:0] vec);
        exp_t x;
        x.tag    = tag;
        x.edge_n = e;
        x.vec    = vec;
        sb.push_back(x);
    endtask

    // Runs the clock up to last_edge, comparing scoreboard entries as their
    // edges arrive; anything left over was never reached and counts as failed.
    task automatic drain(input int last_edge);
        exp_t x;
        while (edge_cnt < last_edge) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
                x = sb.pop_front();
                $display("edge %0d %s obs=%b exp=%b", edge_cnt, x.tag, outs(), x.vec);
                check_val(x.tag, {2'b00, outs()}, {2'b00, x.vec});
            end
        end
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: edge %0d not reached (now %0d), expected %b",
                     x.tag, x.edge_n, edge_cnt, x.vec);
        end
    endtask

    // Invariants sampled on every falling edge.
    always @(negedge clk) begin
        check_val("inv_order", {7'b0, periph_rst_o & ~core_rst_o}, 8'h00);
        check_val("inv_ready", {7'b0, sys_ready_o ^ core_rst_o}, 8'h01);
    end

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw_rst_req_i = 1'b0;
        ext_hold_i   = 1'b0;
        reset        = 1'b0;
        #1 reset = 1'b1;
        #1 check_val("por_async", {2'b00, outs()}, {2'b00, v(1, 1, 0, 0, 2'b00)});

        // Power-on sequence.
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        push("por_e1",  1,  v(1, 1, 0, 0, 2'b00));
        push("por_e15", 15, v(1, 1, 0, 0, 2'b00));
        push("por_e16", 16, v(0, 1, 0, 0, 2'b00));
        push("por_e23", 23, v(0, 1, 0, 0, 2'b00));
        push("por_e24", 24, v(0, 0, 1, 0, 2'b00));
        drain(30);

        // Software reset: request sampled at edge 32.
        fork
            begin
                wait (edge_cnt == 31); #1 sw_rst_req_i = 1'b1;
                wait (edge_cnt == 32); #1 sw_rst_req_i = 1'b0;
            end
        join_none
        push("sw_e31", 31, v(0, 0, 1, 0, 2'b00));
        push("sw_ack", 32, v(1, 1, 0, 1, 2'b01));
        push("sw_e33", 33, v(1, 1, 0, 0, 2'b01));
        push("sw_e36", 36, v(1, 1, 0, 0, 2'b01));
        push("sw_e51", 51, v(1, 1, 0, 0, 2'b01));
        push("sw_e52", 52, v(0, 1, 0, 0, 2'b01));
        push("sw_e59", 59, v(0, 1, 0, 0, 2'b01));
        push("sw_e60", 60, v(0, 0, 1, 0, 2'b01));
        drain(62);

        // External hold: core kept in reset until ext_hold_i sampled low at 41.
        #1 reset = 1'b1;
        ext_hold_i = 1'b1;
        #1 check_val("hold_async", {2'b00, outs()}, {2'b00, v(1, 1, 0, 0, 2'b00)});
        release_reset();
        fork
            begin
                wait (edge_cnt == 40); #1 ext_hold_i = 1'b0;
            end
        join_none
        push("hold_e16", 16, v(0, 1, 0, 0, 2'b00));
        push("hold_e24", 24, v(0, 1, 0, 0, 2'b00));
        push("hold_e40", 40, v(0, 1, 0, 0, 2'b00));
        push("hold_e41", 41, v(0, 0, 1, 0, 2'b00));
        drain(42);

        // Request held outside RUN is ignored.
        #1 reset = 1'b1;
        #1 check_val("ign_async", {2'b00, outs()}, {2'b00, v(1, 1, 0, 0, 2'b00)});
        sw_rst_req_i = 1'b1;
        release_reset();
        fork
            begin
                wait (edge_cnt == 10); #1 sw_rst_req_i = 1'b0;
            end
        join_none
        for (int i = 1; i <= 12; i++) push($sformatf("ign_e%0d", i), i, v(1, 1, 0, 0, 2'b00));
        push("ign_e16", 16, v(0, 1, 0, 0, 2'b00));
        push("ign_e24", 24, v(0, 0, 1, 0, 2'b00));
        drain(26);

        // Async reset in the middle of SW_RST, while the ack is high.
        fork
            begin
                wait (edge_cnt == 27); #1 sw_rst_req_i = 1'b1;
                wait (edge_cnt == 28); #1 sw_rst_req_i = 1'b0;
            end
        join_none
        push("mid_ack", 28, v(1, 1, 0, 1, 2'b01));
        drain(28);
        #2 reset = 1'b1;
        #1 check_val("mid_async", {2'b00, outs()}, {2'b00, v(1, 1, 0, 0, 2'b00)});
        release_reset();
        push("mid_e1",  1,  v(1, 1, 0, 0, 2'b00));
        push("mid_e15", 15, v(1, 1, 0, 0, 2'b00));
        push("mid_e16", 16, v(0, 1, 0, 0, 2'b00));
        push("mid_e23", 23, v(0, 1, 0, 0, 2'b00));
        push("mid_e24", 24, v(0, 0, 1, 0, 2'b00));
        drain(26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
